// File: rtl/dmem_ctrl.sv
// RV32 data memory controller: valid/ready request port, programmable wait states,
// byte-lane stores, sign/zero-extended loads and fault detection.
module dmem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY     = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault
);

  localparam int unsigned AW  = $clog2(DEPTH_WORDS);
  localparam int unsigned TOP = AW + 2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_r;
  logic [3:0]    cnt_r;
  logic          we_r;
  logic [31:0]   addr_r;
  logic [31:0]   wdata_r;
  logic [2:0]    funct3_r;
  logic [31:0]   mem_r [DEPTH_WORDS];

  logic [1:0]    size_s;
  logic          legal_s;
  logic          unsigned_s;
  logic          misalign_s;
  logic          oor_s;
  logic          fault_s;
  logic          access_s;
  logic [AW-1:0] idx_s;
  logic [31:0]   rd_word_s;
  logic [7:0]    byte_s;
  logic [15:0]   half_s;
  logic [31:0]   load_s;
  logic [3:0]    wmask_s;
  logic [31:0]   wword_s;

  assign idx_s      = addr_r[TOP-1:2];
  assign rd_word_s  = mem_r[idx_s];
  assign oor_s      = (addr_r >> TOP) != 32'd0;
  assign misalign_s = ((size_s == 2'd1) && addr_r[0]) ||
                      ((size_s == 2'd2) && (addr_r[1:0] != 2'b00));
  assign fault_s    = !legal_s || misalign_s || oor_s;
  assign access_s   = (state_r == WAIT) && (cnt_r == 4'd0);
  assign byte_s     = rd_word_s[{addr_r[1:0], 3'b000} +: 8];
  assign half_s     = addr_r[1] ? rd_word_s[31:16] : rd_word_s[15:0];

  // Decode access size and funct3 legality; unsigned forms exist only for loads.
  always_comb begin
    size_s     = 2'd0;
    legal_s    = 1'b0;
    unsigned_s = 1'b0;
    case (funct3_r)
      3'b000: begin size_s = 2'd0; legal_s = 1'b1; end
      3'b001: begin size_s = 2'd1; legal_s = 1'b1; end
      3'b010: begin size_s = 2'd2; legal_s = 1'b1; end
      3'b100: begin size_s = 2'd0; legal_s = !we_r; unsigned_s = 1'b1; end
      3'b101: begin size_s = 2'd1; legal_s = !we_r; unsigned_s = 1'b1; end
      default: begin size_s = 2'd0; legal_s = 1'b0; unsigned_s = 1'b0; end
    endcase
  end

  // Load extension and store lane mask/replicated write data.
  always_comb begin
    load_s  = 32'd0;
    wmask_s = 4'b0000;
    wword_s = 32'd0;
    case (size_s)
      2'd0: begin
        load_s  = unsigned_s ? {24'd0, byte_s} : {{24{byte_s[7]}}, byte_s};
        wmask_s = 4'b0001 << addr_r[1:0];
        wword_s = {4{wdata_r[7:0]}};
      end
      2'd1: begin
        load_s  = unsigned_s ? {16'd0, half_s} : {{16{half_s[15]}}, half_s};
        wmask_s = addr_r[1] ? 4'b1100 : 4'b0011;
        wword_s = {2{wdata_r[15:0]}};
      end
      2'd2: begin
        load_s  = rd_word_s;
        wmask_s = 4'b1111;
        wword_s = wdata_r;
      end
      default: begin
        load_s  = 32'd0;
        wmask_s = 4'b0000;
        wword_s = 32'd0;
      end
    endcase
  end

  // Byte-lane write at the access edge; memory itself is never reset, but an
  // edge coinciding with reset must not write.
  always_ff @(posedge clk) begin
    if (rst_n && access_s && we_r && !fault_s) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask_s[i]) begin
          mem_r[idx_s][8*i +: 8] <= wword_s[8*i +: 8];
        end
      end
    end
  end

  // Request/wait/response sequencing with registered handshake and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      we_r       <= 1'b0;
      addr_r     <= 32'd0;
      wdata_r    <= 32'd0;
      funct3_r   <= 3'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_fault <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            we_r      <= req_we;
            addr_r    <= req_addr;
            wdata_r   <= req_wdata;
            funct3_r  <= req_funct3;
            cnt_r     <= 4'(LATENCY);
            req_ready <= 1'b0;
            state_r   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            resp_rdata <= (fault_s || we_r) ? 32'd0 : load_s;
            resp_fault <= fault_s;
            resp_valid <= 1'b1;
            state_r    <= RESP;
          end
        end
        RESP: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state_r    <= IDLE;
        end
        default: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: four instances with LATENCY 0, 5, 1 and 4 share one clock.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic [3:0]  rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_we;
  logic [31:0] req_addr   [4];
  logic [31:0] req_wdata  [4];
  logic [2:0]  req_funct3 [4];
  wire  [3:0]  req_ready;
  wire  [3:0]  resp_valid;
  wire  [3:0]  resp_fault;
  wire  [31:0] resp_rdata [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    dmem_ctrl #(
      .DEPTH_WORDS(64),
      .LATENCY((g == 0) ? 0 : (g == 1) ? 5 : (g == 2) ? 1 : 4)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_funct3(req_funct3[g]),
      .resp_valid(resp_valid[g]),
      .resp_rdata(resp_rdata[g]),
      .resp_fault(resp_fault[g])
    );
  end

  // One transaction: wait for ready, handshake, then wait for the response pulse.
  // lat counts edges from the handshake edge to the sample showing resp_valid.
  task automatic do_req(input int k, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3,
                        output logic [31:0] rd, output logic flt, output int lat);
    int w;
    req_valid[k] = 1'b1; req_we[k] = we; req_addr[k] = addr;
    req_wdata[k] = wdata; req_funct3[k] = f3;
    w = 0;
    while (!req_ready[k] && w < 50) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    lat = 0;
    while (!resp_valid[k] && lat < 50) begin @(posedge clk); #1; lat++; end
    rd = resp_rdata[k];
    flt = resp_fault[k];
  endtask

  task automatic test_reset();
    rst_n = 4'h0; req_valid = 4'h0; req_we = 4'h0;
    for (int i = 0; i < 4; i++) begin
      req_addr[i] = 32'd0; req_wdata[i] = 32'd0; req_funct3[i] = 3'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 4'hF) begin errors++; $display("FAIL reset_ready got %h exp f", req_ready); end
    checks++;
    if (resp_valid !== 4'h0) begin errors++; $display("FAIL reset_valid got %h exp 0", resp_valid); end
    checks++;
    if (resp_fault !== 4'h0) begin errors++; $display("FAIL reset_fault got %h exp 0", resp_fault); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (resp_rdata[i] !== 32'd0) begin
        errors++; $display("FAIL reset_rdata[%0d] got %h exp 0", i, resp_rdata[i]);
      end
    end
    rst_n = 4'hF;
    @(posedge clk); #1;
  endtask

  task automatic test_word();
    logic [31:0] rd; logic flt; int lat;
    do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, rd, flt, lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL sw_latency got %0d exp 1", lat); end
    checks++;
    if (flt !== 1'b0 || rd !== 32'd0) begin
      errors++; $display("FAIL sw_resp got fault=%b rdata=%h exp 0/0", flt, rd);
    end
    do_req(0, 1'b0, 32'h10, 32'h0, 3'b010, rd, flt, lat);
    checks++;
    if (rd !== 32'hDEADBEEF || flt !== 1'b0) begin
      errors++; $display("FAIL lw_word got %h/%b exp deadbeef/0", rd, flt);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; logic flt; int lat;
    logic [31:0] la [7] = '{32'h20, 32'h21, 32'h21, 32'h22, 32'h22, 32'h23, 32'h20};
    logic [2:0]  lf [7] = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b100};
    logic [31:0] le [7] = '{32'hF00D8000, 32'hFFFFFF80, 32'h00000080, 32'hFFFFF00D,
                            32'h0000F00D, 32'hFFFFFFF0, 32'h00000000};
    do_req(0, 1'b1, 32'h20, 32'h0, 3'b010, rd, flt, lat);
    do_req(0, 1'b1, 32'h21, 32'hAAAAAA80, 3'b000, rd, flt, lat);
    do_req(0, 1'b1, 32'h22, 32'h5555F00D, 3'b001, rd, flt, lat);
    for (int i = 0; i < 7; i++) begin
      do_req(0, 1'b0, la[i], 32'h0, lf[i], rd, flt, lat);
      checks++;
      if (rd !== le[i] || flt !== 1'b0) begin
        errors++;
        $display("FAIL lane_load[%0d] addr=%h f3=%b got %h/%b exp %h/0", i, la[i], lf[i], rd, flt, le[i]);
      end
    end
  endtask

  task automatic test_faults();
    logic [31:0] rd; logic flt; int lat;
    logic        fw [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] fa [6] = '{32'h13, 32'h11, 32'h10, 32'h100, 32'h110, 32'h12};
    logic [2:0]  ff [6] = '{3'b010, 3'b001, 3'b100, 3'b010, 3'b010, 3'b010};
    for (int i = 0; i < 6; i++) begin
      do_req(0, fw[i], fa[i], 32'h12345678, ff[i], rd, flt, lat);
      checks++;
      if (flt !== 1'b1 || rd !== 32'd0 || lat !== 1) begin
        errors++;
        $display("FAIL fault[%0d] got fault=%b rdata=%h lat=%0d exp 1/0/1", i, flt, rd, lat);
      end
    end
    do_req(0, 1'b0, 32'h10, 32'h0, 3'b010, rd, flt, lat);
    checks++;
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL fault_nowrite got %h exp deadbeef", rd); end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic flt; int lat;
    int low_cnt; int resp_cnt; int resp_idx; logic resp_flt;
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h40;
    req_wdata[1] = 32'hCAFEF00D; req_funct3[1] = 3'b010;
    @(posedge clk); #1;
    req_valid[1] = 1'b0; req_we[1] = 1'b0; req_addr[1] = 32'h44;
    req_wdata[1] = 32'h0; req_funct3[1] = 3'b111;
    low_cnt = 0; resp_cnt = 0; resp_idx = -1; resp_flt = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!req_ready[1]) low_cnt++;
      if (resp_valid[1]) begin resp_cnt++; resp_idx = i; resp_flt = resp_fault[1]; end
      @(posedge clk); #1;
    end
    checks++;
    if (low_cnt !== 7) begin errors++; $display("FAIL wait_ready_low got %0d exp 7", low_cnt); end
    checks++;
    if (resp_cnt !== 1 || resp_idx !== 6 || resp_flt !== 1'b0) begin
      errors++; $display("FAIL wait_resp got n=%0d at=%0d fault=%b exp 1/6/0", resp_cnt, resp_idx, resp_flt);
    end
    do_req(1, 1'b0, 32'h40, 32'h0, 3'b010, rd, flt, lat);
    checks++;
    if (rd !== 32'hCAFEF00D || lat !== 6) begin
      errors++; $display("FAIL wait_reread got %h lat=%0d exp cafef00d lat=6", rd, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic flt; int lat;
    int acc_cyc [3]; logic [31:0] got [3]; int resp_cyc [3];
    int n_acc; int n_resp; int c; logic acc;
    do_req(2, 1'b1, 32'h0, 32'h11111111, 3'b010, rd, flt, lat);
    do_req(2, 1'b1, 32'h4, 32'h22222222, 3'b010, rd, flt, lat);
    do_req(2, 1'b1, 32'h8, 32'h33333333, 3'b010, rd, flt, lat);
    req_valid[2] = 1'b1; req_we[2] = 1'b0; req_addr[2] = 32'h0; req_funct3[2] = 3'b010;
    n_acc = 0; n_resp = 0; c = 0;
    while (n_resp < 3 && c < 60) begin
      acc = req_ready[2] && req_valid[2];
      @(posedge clk); #1; c++;
      if (acc) begin
        acc_cyc[n_acc] = c; n_acc++;
        if (n_acc == 3) req_valid[2] = 1'b0;
        else req_addr[2] = req_addr[2] + 32'd4;
      end
      if (resp_valid[2]) begin got[n_resp] = resp_rdata[2]; resp_cyc[n_resp] = c; n_resp++; end
    end
    req_valid[2] = 1'b0;
    checks++;
    if (n_resp !== 3 || n_acc !== 3) begin
      errors++; $display("FAIL b2b_count got acc=%0d resp=%0d exp 3/3", n_acc, n_resp);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== {8{4'(i + 1)}} || resp_cyc[i] - acc_cyc[i] !== 2) begin
          errors++;
          $display("FAIL b2b_resp[%0d] got %h delay=%0d exp %h delay=2", i, got[i],
                   resp_cyc[i] - acc_cyc[i], {8{4'(i + 1)}});
        end
      end
      checks++;
      if (acc_cyc[1] - acc_cyc[0] !== 4 || acc_cyc[2] - acc_cyc[1] !== 4) begin
        errors++; $display("FAIL b2b_spacing got %0d,%0d exp 4,4", acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic flt; int lat; int w; int n_resp;
    do_req(3, 1'b1, 32'h30, 32'hAAAA5555, 3'b010, rd, flt, lat);
    req_valid[3] = 1'b1; req_we[3] = 1'b1; req_addr[3] = 32'h30;
    req_wdata[3] = 32'hBBBBBBBB; req_funct3[3] = 3'b010;
    w = 0;
    while (!req_ready[3] && w < 50) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n[3] = 1'b0;
    @(posedge clk); #1;
    rst_n[3] = 1'b1;
    checks++;
    if (req_ready[3] !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b exp 1", req_ready[3]); end
    n_resp = 0;
    for (int i = 0; i < 10; i++) begin
      if (resp_valid[3]) n_resp++;
      @(posedge clk); #1;
    end
    checks++;
    if (n_resp !== 0) begin errors++; $display("FAIL rstmid_noresp got %0d exp 0", n_resp); end
    do_req(3, 1'b0, 32'h30, 32'h0, 3'b010, rd, flt, lat);
    checks++;
    if (rd !== 32'hAAAA5555) begin errors++; $display("FAIL rstmid_nowrite got %h exp aaaa5555", rd); end
    do_req(3, 1'b1, 32'h34, 32'hCCCCCCCC, 3'b010, rd, flt, lat);
    rst_n[3] = 1'b0;
    @(posedge clk); #1;
    rst_n[3] = 1'b1;
    do_req(3, 1'b0, 32'h34, 32'h0, 3'b010, rd, flt, lat);
    checks++;
    if (rd !== 32'hCCCCCCCC) begin errors++; $display("FAIL rstlate_persist got %h exp cccccccc", rd); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_lanes();
    test_faults();
    test_wait_states();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
